// File: rtl/ldm_pkg.sv
// Shared definitions for the LED dot-matrix scan controller: matrix geometry,
// scan FSM states and the row-slice helper.
package ldm_pkg;

    localparam int unsigned ROWS    = 16;
    localparam int unsigned COLS    = 16;
    localparam int unsigned FRAME_W = ROWS * COLS;

    typedef enum logic [1:0] {
        LOAD,
        STROBE,
        DISPLAY,
        BLANK
    } scan_state_e;

    // Row 0 occupies the most significant COLS bits of a frame.
    function automatic logic [COLS-1:0] row_slice(input logic [FRAME_W-1:0] frame,
                                                  input logic [3:0]         row);
        return frame[(FRAME_W - 1) - COLS * int'(row) -: COLS];
    endfunction

endpackage

// File: rtl/ldm_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer to the requester
// that should win the next contested cycle.
module ldm_rr_arb (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       rr_ptr_nxt
);

    // rr_ptr names the requester preferred on a tie (0 = req0).
    always_comb begin
        grant = '0;
        if (valid0 && valid1) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end

        rr_ptr_nxt = rr_ptr;
        if (grant[0]) begin
            rr_ptr_nxt = 1'b1;
        end else if (grant[1]) begin
            rr_ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/ldm_scan_ctrl.sv
// Double-buffered 16x16 LED matrix row scanner with two round-robin frame sources.
// Define LDM_SCAN_BLANK_EN to add a one-tick blanking state after each row.
module ldm_scan_ctrl
    import ldm_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned DWELL = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] req0_data,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [FRAME_W-1:0] req1_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    output logic               ldm_clk,
    output logic               ldm_addr_en,
    output logic [3:0]         ldm_addr,
    output logic [COLS-1:0]    ldm_line_data,
    output logic               frame_swap
);

    logic [7:0]         presc;
    logic               tick;
    logic [FRAME_W-1:0] front;
    logic [FRAME_W-1:0] back;
    logic               back_full;
    logic               rr_ptr;
    logic               rr_ptr_nxt;
    logic [1:0]         grant;
    logic               xfer;
    scan_state_e        state;
    logic [7:0]         dwell_cnt;
    logic               dwell_last;
    logic               leave_row;
    logic               swap;
    logic [3:0]         row_nxt;

    ldm_rr_arb u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .rr_ptr_nxt (rr_ptr_nxt)
    );

    assign req0_ready = !back_full;
    assign req1_ready = !back_full;
    assign xfer       = !back_full && (grant != 2'b00);

    assign tick       = (presc == 8'(DIV - 1));
    assign dwell_last = (dwell_cnt == 8'(DWELL - 1));
    assign row_nxt    = ldm_addr + 4'd1;

    always_comb begin
        leave_row = 1'b0;
        if (tick) begin
`ifdef LDM_SCAN_BLANK_EN
            leave_row = (state == BLANK);
`else
            leave_row = (state == DISPLAY) && dwell_last;
`endif
        end
    end

    // A swap needs back_full, a transfer needs !back_full, so they never collide.
    assign swap = leave_row && (ldm_addr == 4'(ROWS - 1)) && back_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc         <= '0;
            front         <= '0;
            back          <= '0;
            back_full     <= 1'b0;
            rr_ptr        <= 1'b0;
            state         <= LOAD;
            dwell_cnt     <= '0;
            ldm_clk       <= 1'b0;
            ldm_addr_en   <= 1'b0;
            ldm_addr      <= '0;
            ldm_line_data <= '0;
            frame_swap    <= 1'b0;
        end else begin
            frame_swap <= 1'b0;
            presc      <= tick ? '0 : presc + 8'd1;

            if (xfer) begin
                back      <= grant[0] ? req0_data : req1_data;
                back_full <= 1'b1;
                rr_ptr    <= rr_ptr_nxt;
            end

            if (swap) begin
                front      <= back;
                back_full  <= 1'b0;
                frame_swap <= 1'b1;
            end

            // Line data is latched on entry to LOAD, from back when this is the swap edge.
            if (leave_row) begin
                state         <= LOAD;
                ldm_addr_en   <= 1'b0;
                ldm_addr      <= row_nxt;
                ldm_line_data <= row_slice(swap ? back : front, row_nxt);
            end else if (tick) begin
                case (state)
                    LOAD: begin
                        state   <= STROBE;
                        ldm_clk <= 1'b1;
                    end
                    STROBE: begin
                        state       <= DISPLAY;
                        ldm_clk     <= 1'b0;
                        ldm_addr_en <= 1'b1;
                        dwell_cnt   <= '0;
                    end
                    DISPLAY: begin
`ifdef LDM_SCAN_BLANK_EN
                        if (dwell_last) begin
                            state       <= BLANK;
                            ldm_addr_en <= 1'b0;
                        end else begin
                            dwell_cnt <= dwell_cnt + 8'd1;
                        end
`else
                        dwell_cnt <= dwell_cnt + 8'd1;
`endif
                    end
                    default: begin
                        state <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Scoreboard bench for ldm_scan_ctrl: scan outputs predicted from elapsed time,
// frame contents predicted from accepted transfers.
module tb_ldm_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DWELL = 8;
`ifdef LDM_SCAN_BLANK_EN
    localparam int unsigned R = DWELL + 3;
`else
    localparam int unsigned R = DWELL + 2;
`endif
    localparam int unsigned FP = 16 * R * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] req0_data = '0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [255:0] req1_data = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic         ldm_clk;
    logic         ldm_addr_en;
    logic [3:0]   ldm_addr;
    logic [15:0]  ldm_line_data;
    logic         frame_swap;

    ldm_scan_ctrl #(.DIV(DIV), .DWELL(DWELL)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_data     (req0_data),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req1_data     (req1_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .ldm_clk       (ldm_clk),
        .ldm_addr_en   (ldm_addr_en),
        .ldm_addr      (ldm_addr),
        .ldm_line_data (ldm_line_data),
        .frame_swap    (frame_swap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        int unsigned  at;
    } sb_t;

    sb_t          sb[$];
    int unsigned  cyc;
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [255:0] disp = '0;

    // Stimulus-side model of the handshake
    bit           v0 = 0, v1 = 0;
    logic [255:0] d0 = '0, d1 = '0;
    bit           m_pend = 0;
    int unsigned  m_swap_at = 0;
    int           m_prio = 0;
    int unsigned  p0 = 0, p1 = 0;
    bit           auto_refill = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rnd_frame();
        logic [255:0] f = '0;
        for (int i = 0; i < 8; i++) f = {f[223:0], 32'($urandom())};
        return f;
    endfunction

    function automatic logic [255:0] ramp_frame();
        logic [255:0] f = '0;
        logic [15:0]  ones = 16'hFFFF;
        for (int r = 0; r < 16; r++) f = {f[239:0], ones >> r};
        return f;
    endfunction

    // Called at posedge+1; applies inputs for the next edge and predicts its outcome.
    task automatic step();
        int unsigned e;
        bit          bf;
        int          g;
        if (!v0 && ($urandom_range(99, 0) < p0)) begin v0 = 1; d0 = rnd_frame(); end
        if (!v1 && ($urandom_range(99, 0) < p1)) begin v1 = 1; d1 = rnd_frame(); end
        e  = cyc + 1;
        bf = m_pend && (e <= m_swap_at);
        chk("req0_ready", {255'b0, req0_ready}, {255'b0, !bf});
        chk("req1_ready", {255'b0, req1_ready}, {255'b0, !bf});
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        g = -1;
        if (!bf) begin
            if (v0 && v1) g = m_prio;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        if (g >= 0) begin
            m_pend    = 1;
            m_swap_at = (e / FP + 1) * FP;
            sb.push_back('{data: (g == 0) ? d0 : d1, at: m_swap_at});
            m_prio    = (g == 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (g == 0) begin
            v0 = auto_refill;
            if (auto_refill) d0 = rnd_frame();
        end
        if (g == 1) begin
            v1 = auto_refill;
            if (auto_refill) d1 = rnd_frame();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        v0 = 0; v1 = 0; m_pend = 0; m_prio = 0;
        sb.delete();
        disp = '0;
        #1;
        chk("rst_immediate", {235'b0, ldm_clk, ldm_addr_en, ldm_addr, ldm_line_data, frame_swap}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int unsigned e, k, p, row, ph;
        if (rst) begin
            chk("rst_outputs", {235'b0, ldm_clk, ldm_addr_en, ldm_addr, ldm_line_data, frame_swap}, '0);
        end else begin
            e = cyc;
            chk("frame_swap", {255'b0, frame_swap}, {255'b0, (sb.size() > 0 && sb[0].at == e)});
            if (sb.size() > 0 && sb[0].at <= e) begin
                disp = sb[0].data;
                void'(sb.pop_front());
            end
            k   = e / DIV;
            p   = k % (16 * R);
            row = p / R;
            ph  = p % R;
            chk("ldm_clk", {255'b0, ldm_clk}, {255'b0, (ph == 1)});
            chk("ldm_addr_en", {255'b0, ldm_addr_en}, {255'b0, (ph >= 2 && ph <= DWELL + 1)});
            chk("ldm_addr", {252'b0, ldm_addr}, 256'(row));
            chk("ldm_line_data", {240'b0, ldm_line_data}, {240'b0, 16'(disp >> (16 * (15 - row)))});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int unsigned target;
        @(posedge clk);
        #1;
        do_reset();

        // All-ones frame on req0 from cycle 1; ramp on req1 queued behind it.
        v0 = 1; d0 = '1;
        repeat (10) step();
        v1 = 1; d1 = ramp_frame();
        while (cyc < 3 * FP - 10) step();

        // Both requesters contending continuously.
        auto_refill = 1;
        if (!v0) begin v0 = 1; d0 = rnd_frame(); end
        if (!v1) begin v1 = 1; d1 = rnd_frame(); end
        repeat (3 * FP) step();
        auto_refill = 0;

        // Reset while row 7 is in DISPLAY with a frame pending.
        if (!v0) begin v0 = 1; d0 = rnd_frame(); end
        target = (cyc / FP + 1) * FP + (7 * R + 4) * DIV;
        while (cyc < target) step();
        do_reset();

        // Sparse random traffic.
        p0 = 2; p1 = 2;
        repeat (6 * FP) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ldm_scan_ctrl.md
LDM_SCAN_CTRL -- requirements
Module: ldm_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: system clocks per scan tick, legal range 2..255.
REQ-002 SHALL have parameter DWELL, default 8: scan ticks each row is lit, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req0_data, input, 256 bits: frame from requester 0.
REQ-006 SHALL have port req0_valid, input, 1 bit: requester 0 offers a frame.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 may transfer.
REQ-008 SHALL have ports req1_data, req1_valid and req1_ready, with the same widths, directions and meanings as the requester 0 ports.
REQ-009 SHALL have port ldm_clk, output, 1 bit: row-latch strobe to the matrix.
REQ-010 SHALL have port ldm_addr_en, output, 1 bit: row-enable, high while the addressed row is lit.
REQ-011 SHALL have port ldm_addr, output, 4 bits: current row index, 0..15.
REQ-012 SHALL have port ldm_line_data, output, 16 bits: column data for the current row.
REQ-013 SHALL have port frame_swap, output, 1 bit: one-cycle pulse when a new frame becomes visible.

Function
REQ-014 SHALL count a prescaler 0..DIV-1 and assert an internal tick when it wraps; the first tick comes DIV cycles after reset release.
REQ-015 SHALL hold two 256-bit buffers: front, which is displayed, and back, which is pending, plus a back_full flag.
REQ-016 SHALL drive reqN_ready = !back_full combinationally, identically for both requesters.
REQ-017 SHALL complete a transfer in a cycle where the granted reqN_valid is high and back_full is 0; that cycle it writes reqN_data into back and sets back_full.
REQ-018 SHALL grant a lone valid requester directly.
REQ-019 SHALL, when both requesters are valid, grant the requester not served by the previous transfer; req0 has priority after reset.
REQ-020 SHALL give an ungranted requester no transfer; that requester must hold valid and data stable.
REQ-021 SHALL run its scan FSM states LOAD, STROBE, DISPLAY and BLANK, advancing only on tick.
REQ-022 SHALL, in LOAD, drive ldm_line_data = front[255-16*row -: 16], so row 0 is the MSB slice; ldm_addr_en is 0 in this state.
REQ-023 SHALL, in STROBE, hold ldm_clk at 1 for the whole tick.
REQ-024 SHALL, in DISPLAY, hold ldm_addr_en at 1 for DWELL ticks.
REQ-025 SHALL, in BLANK, hold ldm_addr_en at 0 for one tick.
REQ-026 SHALL increment the row on leaving the last row state and wrap from 15 to 0.
REQ-027 SHALL, at the frame boundary (row 15 to 0) with back_full = 1, copy back into front, clear back_full and pulse frame_swap in the same cycle.
REQ-028 SHALL show new data starting at row 0 after a swap and never tear a frame mid-scan.
REQ-029 SHALL never coincide a transfer with a swap, because a transfer requires back_full = 0 and a swap requires back_full = 1.
REQ-030 SHALL, at a frame boundary with back_full = 0, keep front and continue scanning without pulsing frame_swap.
REQ-031 SHALL drive all scan outputs from registers; ldm_addr changes only in LOAD.

Reset
REQ-032 SHALL, while rst is high, hold ldm_clk = 0, ldm_addr_en = 0, ldm_addr = 0, ldm_line_data = 0 and frame_swap = 0.
REQ-033 SHALL, while rst is high, hold front = 0, back = 0, back_full = 0, FSM = LOAD, row = 0, prescaler = 0 and round-robin pointer = req0.
REQ-034 SHALL, on reset mid-operation, take effect immediately, discard the pending frame and restart the scan at row 0 in LOAD.

Configuration
REQ-035 SHALL, with macro LDM_SCAN_BLANK_EN defined, include the BLANK state; a row is then 1+1+DWELL+1 ticks.
REQ-036 SHALL, without LDM_SCAN_BLANK_EN, go directly from DISPLAY to the next LOAD; a row is then 1+1+DWELL ticks.

Structure
REQ-037 SHALL take the scan state enum and the constants ROWS=16, COLS=16 and FRAME_W=256 from the shared package ldm_pkg.
REQ-038 SHALL instantiate one sub-module, ldm_rr_arb, a 2-way round-robin arbiter producing a one-hot grant and an updated last-served pointer.

Verification
REQ-039 SHALL cover: reset, then req0 presents all-0xFFFF with DIV=4 and DWELL=8 -> transfer in cycle 1; frame_swap at the first frame boundary (cycle 704 with blanking, 640 without); row 0 then shows ldm_line_data=16'hFFFF.
REQ-040 SHALL cover: the ramp frame 256'hffff_7fff_..._0003_0001 -> row r shows 16'hFFFF >> r for r=0..15; ldm_addr walks 0..15 and wraps.
REQ-041 SHALL cover: req0 and req1 valid together over three frames -> grants alternate req0, req1, req0; each frame is visible for exactly one frame period.
REQ-042 SHALL cover: a second frame offered while back_full=1 -> ready stays 0 until the swap cycle, and the transfer completes the cycle after.
REQ-043 SHALL cover: rst pulsed while row 7 is in DISPLAY -> all outputs are 0 at once; the pending frame is lost; the scan restarts at row 0.
REQ-044 SHALL cover: each row of the scan sequence -> ldm_clk high for exactly DIV cycles per row and ldm_addr_en high for DWELL*DIV = 32 cycles per row.
